pipe_stage_reg: RTL

Parametrised elastic pipeline register that replaces the per-stage fixed-format pipeline registers between IF/ID/EX/MEM/WB. Each instance carries one opaque payload word plus a PC field, with valid/ready handshaking on both sides. An optional two-entry skid buffer lets the stage register its ready output. It also supports flush-to-bubble, halt freeze and order-preserving back-pressure, so global combinational stall wiring across the core is no longer needed.

---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush-to-bubble and halt freeze.
// Optional 2-entry skid (SKID=1); PIPE_STAGE_STATS_EN adds stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 22,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
`ifdef PIPE_STAGE_STATS_EN
  input  logic              hlt,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`else
  input  logic              hlt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic accept;
  logic deliver;

  // With a skid entry, in_ready depends only on state and hlt, never on out_ready.
  always_comb begin
    if (SKID != 0) begin
      in_ready = ~s_valid_q & ~hlt;
    end else begin
      in_ready = (~m_valid_q | out_ready) & ~hlt;
    end
  end

  assign out_valid = m_valid_q & ~hlt;
  assign out_pc    = m_pc_q;
  assign out_data  = m_data_q;

  assign accept  = in_valid & in_ready & ~flush;
  assign deliver = out_valid & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if ((SKID != 0) && s_valid_q) begin
      // FULL: accept is impossible; a delivery promotes the skid beat to head.
      if (deliver) begin
        m_pc_d    = s_pc_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if ((SKID != 0) && accept && m_valid_q && !deliver) begin
      s_valid_d = 1'b1;
      s_pc_d    = in_pc;
      s_data_d  = in_data;
    end else begin
      if (deliver) begin
        m_valid_d = 1'b0;
      end
      if (accept) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;
  logic        stall_now;
  logic        bubble_now;

  assign stall_now  = out_valid & ~out_ready;
  assign bubble_now = out_ready & ~out_valid & ~hlt;

  // Saturating counters; flush deliberately has no effect on them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (stall_now && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (bubble_now && (bubble_q != 32'hFFFF_FFFF)) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule
